// File: rtl/wm8731_coeff_pkg.sv
// Shared types and constants for the WM8731 FIR coefficient load path.
package wm8731_coeff_pkg;

  localparam int unsigned STAGE_DEFAULT = 256;
  localparam int unsigned COEFF_W       = 16;
  localparam int unsigned ADDR_W        = 9;

  // Fixed encodings keep the state values identical to the legacy netlist.
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_HI        = 3'd1;
  localparam logic [2:0] ST_LO        = 3'd2;
  localparam logic [2:0] ST_WR        = 3'd3;
  localparam logic [2:0] ST_WAIT_SWAP = 3'd4;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    HI        = ST_HI,
    LO        = ST_LO,
    WR        = ST_WR,
    WAIT_SWAP = ST_WAIT_SWAP
  } state_t;

endpackage

// File: rtl/coeff_idle_timer.sv
// Reloadable down-counter; expire pulses on the TIMEOUT-th consecutive enabled cycle.
module coeff_idle_timer #(
  parameter int unsigned TIMEOUT = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LOAD = W'(TIMEOUT);
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= LOAD;
    else if (en && cnt != ONE)
      cnt <= cnt - ONE;
  end

  assign expire = en && (cnt == ONE);

endmodule

// File: rtl/coeff_load_ctrl.sv
// Packs host byte pairs into FIR coefficients, writes the shadow bank when the
// RAM is free, and issues a bank swap at a sample-computation gap.
module coeff_load_ctrl
  import wm8731_coeff_pkg::*;
#(
  parameter int unsigned STAGE   = STAGE_DEFAULT,
  parameter int unsigned TIMEOUT = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_sof,
  output logic        in_ready,
  input  logic        ram_free,
  input  logic        frame_gap,
  output logic [8:0]  wr_addr,
  output logic [15:0] wr_coeff,
  output logic        wr_en,
  output logic        coeff_up,
  output logic        busy,
  output logic        load_done,
  output logic        load_err,
  output logic        bank_sel
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(STAGE - 1);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

  state_t            state;
  logic [7:0]        hi_byte;
  logic [ADDR_W-1:0] idx;
  logic              accept;
  logic              in_frame;
  logic              expire;

  assign in_ready = !rst && (state == IDLE || state == HI || state == LO);
  assign accept   = in_valid && in_ready;
  assign in_frame = (state == HI) || (state == LO);
  assign wr_en    = !rst && (state == WR) && ram_free;
  assign coeff_up = !rst && (state == WAIT_SWAP) && frame_gap;
  assign busy     = !rst && (state != IDLE);

  coeff_idle_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (!in_frame || accept),
    .en     (in_frame && !accept),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hi_byte   <= '0;
      idx       <= '0;
      wr_addr   <= '0;
      wr_coeff  <= '0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      bank_sel  <= 1'b0;
    end else begin
      load_done <= 1'b0;
      load_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && in_sof) begin
            hi_byte <= in_data;
            idx     <= '0;
            state   <= LO;
          end
        end
        HI, LO: begin
          if (accept) begin
            // A mid-frame sof restarts the set from coefficient 0 without swapping.
            if (in_sof) begin
              load_err <= 1'b1;
              hi_byte  <= in_data;
              idx      <= '0;
              state    <= LO;
            end else if (state == HI) begin
              hi_byte <= in_data;
              state   <= LO;
            end else begin
              wr_coeff <= {hi_byte, in_data};
              wr_addr  <= idx;
              state    <= WR;
            end
          end else if (expire) begin
            load_err <= 1'b1;
            state    <= IDLE;
          end
        end
        WR: begin
          if (ram_free) begin
            if (idx == LAST) begin
              state <= WAIT_SWAP;
            end else begin
              idx   <= idx + ONE;
              state <= HI;
            end
          end
        end
        WAIT_SWAP: begin
          if (frame_gap) begin
            load_done <= 1'b1;
            bank_sel  <= ~bank_sel;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/coeff_load_ctrl.md
# coeff_load_ctrl

Sequencer that loads a new FIR coefficient set into the ping-pong coefficient RAM (`coeff_reg`) of the WM8731 audio path. It takes a byte stream from the host/UART side and packs byte pairs into 16-bit coefficients. Writes go into the shadow bank only in cycles when the FIR engine is not reading the RAM. Once a full set is written, it swaps banks at a sample-computation gap.

## Interface

Parameters:
- `STAGE`, 256: coefficients per set. Range 2..256; must equal `coeff_reg` `STAGE`.
- `TIMEOUT`, 1_000_000: idle clk cycles allowed between bytes of one frame before the frame is aborted.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: byte valid.
- `in_data` in 8: byte.
- `in_sof` in 1: byte is the first of a frame (high byte of coefficient 0).
- `in_ready` out 1: byte accepted when `in_valid && in_ready`.
- `ram_free` in 1: FIR engine is not reading the coefficient RAM this cycle.
- `frame_gap` in 1: FIR engine is between sample computations. A bank swap is legal in this cycle.
- `wr_addr` out 9: coefficient index to `coeff_reg`.
- `wr_coeff` out 16: coefficient to `coeff_reg`.
- `wr_en` out 1: write strobe to `coeff_reg`.
- `coeff_up` out 1: one-cycle bank-swap pulse to `coeff_reg`.
- `busy` out 1: a frame is in progress (any state except IDLE).
- `load_done` out 1: one-cycle pulse when the swap is issued.
- `load_err` out 1: one-cycle pulse when a frame is aborted.
- `bank_sel` out 1: mirror of the `coeff_reg` write-pointer state. Toggles with each `coeff_up`.

## Operation

- Frame format: `STAGE` coefficients, each sent as a byte pair, high byte first. The first byte of the frame carries `in_sof`.
- States:
  - IDLE: `in_ready`=1.
    - Byte with `in_sof` is stored as the high byte; index := 0; go to LO.
    - Byte without `in_sof` is discarded silently.
  - HI: `in_ready`=1.
    - Byte without `in_sof` is stored as the high byte; go to LO.
  - LO: `in_ready`=1.
    - Byte without `in_sof`: `wr_coeff` := {high, byte}; `wr_addr` := index; go to WR.
  - WR: `in_ready`=0.
    - `wr_en` = `ram_free` (combinational). Writes are never issued while the FIR engine is reading, because `coeff_reg` lets a write override the read address.
    - On a cycle with `ram_free`=1: if index = `STAGE`-1, go to WAIT_SWAP; otherwise index++ and go to HI.
  - WAIT_SWAP: `in_ready`=0.
    - `coeff_up` = `frame_gap` (combinational).
    - On a cycle with `frame_gap`=1: `load_done` pulses, `bank_sel` toggles, go to IDLE.
- Mid-frame `in_sof` (byte accepted in HI or LO with `in_sof`=1):
  - `load_err` pulses.
  - The partial set is abandoned (shadow bank keeps partial data, which is harmless because there is no swap).
  - The byte is taken as the high byte of coefficient 0; index := 0; go to LO.
- Timeout: a counter runs in HI/LO and clears on each accepted byte.
  - Reaching `TIMEOUT` causes a `load_err` pulse and a return to IDLE.
  - The counter does not run in WR or WAIT_SWAP.
- `wr_addr` and `wr_coeff` are registered and held stable throughout WR. They retain their last value otherwise.
- `rst` mid-frame: return to IDLE, no swap, no `load_err`. `bank_sel` := 0, which matches the `coeff_reg` reset.

## Timing

- Reset values:
  - `in_ready`, `wr_en`, `coeff_up`, `busy`, `load_done`, `load_err`, `bank_sel` = 0.
  - `wr_addr` = 0, `wr_coeff` = 0.
  - `in_ready` is forced low while `rst`=1.
- Byte accept to state change: 1 clk.
- LO accept to earliest `wr_en`: 1 clk (next cycle, if `ram_free`=1).
- Minimum frame duration with `ram_free` held at 1: 3·`STAGE` clk, plus the wait for `frame_gap`.
- `load_done` and `load_err` are registered. They assert the cycle after the causing event and last 1 clk.
- `coeff_up` and the final state exit share the same clk edge.

## Structure

- Shared package `wm8731_coeff_pkg`:
  - State enum (IDLE, HI, LO, WR, WAIT_SWAP).
  - Default `STAGE` = 256.
  - Coefficient width 16, address width 9.
- One sub-module, `coeff_idle_timer`: a loadable down-counter with clear and enable that emits a terminal pulse.
- The top level instantiates the controller alone. Integration connects it to `coeff_reg` at the audio-path level.

## Test plan

All scenarios use STAGE=4 and TIMEOUT=20.

1. Clean load, `ram_free`=1, `frame_gap` held at 0, bytes 12 34 56 78 9A BC DE F0 with sof on the first byte:
   - Writes addr 0..3 with 0x1234, 0x5678, 0x9ABC, 0xDEF0.
   - Block waits in WAIT_SWAP.
   - Raising `frame_gap` gives one `coeff_up`, one `load_done`, and `bank_sel`=1.
2. `ram_free` toggling 0,0,1 while in WR: `wr_en` asserts only on the `ram_free`=1 cycle, and `wr_addr`/`wr_coeff` stay stable throughout.
3. `in_sof` on the 5th byte: `load_err` pulses once, the index restarts at 0, and the next byte completes coefficient 0 at addr 0.
4. Stall 20 cycles after the 3rd byte: `load_err` pulses, `busy`=0, there is no `coeff_up`, and `bank_sel` is unchanged.
5. Bytes without sof in IDLE: all accepted and discarded, with no `wr_en` and no error.
6. Assert `rst` during WAIT_SWAP: no `coeff_up`, all outputs return to reset values, and the next sof frame loads normally.
